// File: rtl/morse_sequencer_if.sv
// morse_sequencer_if: symbol handshake and key/status bundle between the
// character source (master) and the Morse sequencer (slave).
`timescale 1ns/1ps
interface morse_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_len;
    logic [4:0] in_pat;
    logic       in_space;
    logic       key;
    logic       busy;
    logic       done;

    modport master (
        output in_valid, in_len, in_pat, in_space,
        input  in_ready, key, busy, done
    );

    modport slave (
        input  in_valid, in_len, in_pat, in_space,
        output in_ready, key, busy, done
    );
endinterface

// File: rtl/morse_sequencer.sv
// morse_sequencer: schedules one Morse symbol at a time onto the key output,
// timing marks and all element/character/word gaps in whole unit ticks.
// Optional feature: define MORSE_ABORT_EN to add a synchronous abort input
// that drops the current symbol and the held one without a done pulse.
`timescale 1ns/1ps
module morse_sequencer #(
    parameter int DOT_UNITS  = 1,
    parameter int DASH_UNITS = 3,
    parameter int GAP_ELEM   = 1,
    parameter int GAP_CHAR   = 3,
    parameter int GAP_WORD   = 7,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef MORSE_ABORT_EN
    input  logic abort,
`endif
    input  logic unit_clk,
    morse_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_MARK  = 3'd2;
    localparam logic [2:0] S_EGAP  = 3'd3;
    localparam logic [2:0] S_CGAP  = 3'd4;
    localparam logic [2:0] S_WGAP  = 3'd5;

    localparam logic [CNT_W-1:0] L_DOT  = CNT_W'(DOT_UNITS);
    localparam logic [CNT_W-1:0] L_DASH = CNT_W'(DASH_UNITS);
    localparam logic [CNT_W-1:0] L_EGAP = CNT_W'(GAP_ELEM);
    localparam logic [CNT_W-1:0] L_CGAP = CNT_W'(GAP_CHAR);
    localparam logic [CNT_W-1:0] L_WGAP = CNT_W'(GAP_WORD - GAP_CHAR);

    // control registers
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hold_valid;
    logic             r_prev_unit;
    logic             r_key;
    logic             r_done;

    // payload registers (no reset needed: qualified by r_hold_valid / r_state)
    logic [2:0]       r_hold_len;
    logic [4:0]       r_hold_pat;
    logic             r_hold_space;
    logic [2:0]       r_rem;
    logic [4:0]       r_pat;
    logic             r_space;

    logic             w_tick;
    logic             w_accept;
    logic             w_abort;
    logic [2:0]       w_len_in;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_mark_tgt;
    logic [CNT_W-1:0] w_gap_tgt;

    logic [2:0]       w_state_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_pop;
    logic             w_done_n;
    logic [2:0]       w_rem_n;
    logic [4:0]       w_pat_n;
    logic             w_space_n;

    assign w_tick     = unit_clk & ~r_prev_unit;
    assign w_accept   = bus.in_valid & ~r_hold_valid;
    assign w_len_in   = (bus.in_len > 3'd5) ? 3'd5 : bus.in_len;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_mark_tgt = r_pat[4] ? L_DASH : L_DOT;
    assign w_gap_tgt  = (r_state == S_WGAP) ? L_WGAP : L_CGAP;

`ifdef MORSE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Next-state logic: counts ticks per state and sequences elements/gaps.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = w_tick ? w_cnt_inc : r_cnt;
        w_pop     = 1'b0;
        w_done_n  = 1'b0;
        w_rem_n   = r_rem;
        w_pat_n   = r_pat;
        w_space_n = r_space;
        case (r_state)
            S_IDLE: begin
                if (r_hold_valid) begin
                    w_pop     = 1'b1;
                    w_state_n = S_ALIGN;
                    w_cnt_n   = '0;
                end
            end
            S_ALIGN: begin
                if (w_tick) begin
                    w_cnt_n = '0;
                    if (r_space) begin
                        w_state_n = S_WGAP;
                    end else if (r_rem == 3'd0) begin
                        w_done_n  = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n = S_MARK;
                    end
                end
            end
            S_MARK: begin
                if (w_tick && (w_cnt_inc == w_mark_tgt)) begin
                    w_cnt_n   = '0;
                    w_state_n = (r_rem > 3'd1) ? S_EGAP : S_CGAP;
                end
            end
            S_EGAP: begin
                if (w_tick && (w_cnt_inc == L_EGAP)) begin
                    w_cnt_n   = '0;
                    w_state_n = S_MARK;
                    w_rem_n   = r_rem - 3'd1;
                    w_pat_n   = {r_pat[3:0], 1'b0};
                end
            end
            S_CGAP, S_WGAP: begin
                if (w_tick && (w_cnt_inc == w_gap_tgt)) begin
                    w_cnt_n  = '0;
                    w_done_n = 1'b1;
                    if (r_hold_valid) begin
                        // Chain straight into the next symbol on this tick;
                        // an empty symbol still needs ALIGN to report done.
                        w_pop = 1'b1;
                        if (r_hold_space)
                            w_state_n = S_WGAP;
                        else if (r_hold_len == 3'd0)
                            w_state_n = S_ALIGN;
                        else
                            w_state_n = S_MARK;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
        if (w_pop) begin
            w_rem_n   = r_hold_len;
            w_pat_n   = r_hold_pat;
            w_space_n = r_hold_space;
        end
        if (w_abort) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_pop     = 1'b0;
            w_done_n  = 1'b0;
        end
    end

    // Control state: FSM, counter, holding flag, tick edge detector, outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_hold_valid <= 1'b0;
            r_prev_unit  <= 1'b1;
            r_key        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_prev_unit <= unit_clk;
            r_key       <= (w_state_n == S_MARK);
            r_done      <= w_done_n;
            if (w_abort)
                r_hold_valid <= 1'b0;
            else if (w_accept)
                r_hold_valid <= 1'b1;
            else if (w_pop)
                r_hold_valid <= 1'b0;
        end
    end

    // Payload capture: holding register on accept, working symbol on pop/advance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold_len   <= w_len_in;
            r_hold_pat   <= bus.in_pat;
            r_hold_space <= bus.in_space;
        end
        r_rem   <= w_rem_n;
        r_pat   <= w_pat_n;
        r_space <= w_space_n;
    end

    assign bus.in_ready = ~r_hold_valid;
    assign bus.key      = r_key;
    assign bus.done     = r_done;
    assign bus.busy     = (r_state != S_IDLE) | r_hold_valid;

endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: directed bench for morse_sequencer with a 20-cycle
// unit clock (10 high, 10 low).
`timescale 1ns/1ps
module tb_morse_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic unit_clk = 1'b0;
`ifdef MORSE_ABORT_EN
    logic abort = 1'b0;
`endif

    int uc_ph = 10;
    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int done_seen = 0;
    int done_cyc = 0;
    int rise_cnt = 0;
    int rise_ph = -1;
    int rise_cyc = 0;
    int fall_cyc = 0;
    logic key_q = 1'b0;

    morse_sequencer_if bus();

    morse_sequencer dut (
        .clk(clk),
        .rst(rst),
`ifdef MORSE_ABORT_EN
        .abort(abort),
`endif
        .unit_clk(unit_clk),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    // unit clock: phase 0..9 high, 10..19 low, updated on the falling clk edge
    initial forever begin
        @(negedge clk);
        uc_ph    = (uc_ph == 19) ? 0 : uc_ph + 1;
        unit_clk = (uc_ph < 10);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (bus.key === 1'b1 && key_q === 1'b0) begin
            rise_cnt++;
            rise_ph  = uc_ph;
            rise_cyc = cyc;
        end
        if (bus.key === 1'b0 && key_q === 1'b1) fall_cyc = cyc;
        key_q = bus.key;
    endtask

    task automatic wait_key(input logic lvl, input int bound, output int n);
        n = 0;
        while (bus.key !== lvl && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic offer(input logic [2:0] len, input logic [4:0] pat, input logic sp);
        bus.in_valid = 1'b1;
        bus.in_len   = len;
        bus.in_pat   = pat;
        bus.in_space = sp;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        nchk++; if (bus.key !== 1'b0) begin nerr++; $display("FAIL rst_key: got %b want 0", bus.key); end
        nchk++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
        nchk++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        nchk++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b want 0", bus.done); end
        rst = 1'b1;
        repeat (45) step();
        nchk++; if (bus.busy !== 1'b0 || done_seen != 0) begin nerr++; $display("FAIL idle_quiet: busy=%b done_seen=%0d want 0/0", bus.busy, done_seen); end
    endtask

    task automatic test_e();
        int n, d0;
        d0 = done_seen;
        offer(3'd1, 5'b00000, 1'b0);
        nchk++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL e_ready_drop: got %b want 0", bus.in_ready); end
        wait_key(1'b1, 100, n);
        nchk++; if (bus.key !== 1'b1 || rise_ph != 0) begin nerr++; $display("FAIL e_rise_on_tick: key=%b phase=%0d want 1/0", bus.key, rise_ph); end
        wait_key(1'b0, 100, n);
        nchk++; if (n != 20) begin nerr++; $display("FAIL e_mark: got %0d cycles want 20", n); end
        wait_done(100, n);
        nchk++; if (n != 60) begin nerr++; $display("FAIL e_cgap: got %0d cycles want 60", n); end
        step();
        nchk++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL e_end: done=%b busy=%b want 0/0", bus.done, bus.busy); end
        nchk++; if (done_seen - d0 != 1) begin nerr++; $display("FAIL e_done_count: got %0d want 1", done_seen - d0); end
    endtask

    task automatic test_a();
        int n, d0;
        d0 = done_seen;
        offer(3'd2, 5'b01000, 1'b0);
        wait_key(1'b1, 100, n);
        wait_key(1'b0, 100, n);
        nchk++; if (n != 20) begin nerr++; $display("FAIL a_dot: got %0d want 20", n); end
        wait_key(1'b1, 100, n);
        nchk++; if (n != 20) begin nerr++; $display("FAIL a_egap: got %0d want 20", n); end
        wait_key(1'b0, 100, n);
        nchk++; if (n != 60) begin nerr++; $display("FAIL a_dash: got %0d want 60", n); end
        wait_done(100, n);
        nchk++; if (n != 60) begin nerr++; $display("FAIL a_cgap: got %0d want 60", n); end
        repeat (2) step();
        nchk++; if (done_seen - d0 != 1 || bus.busy !== 1'b0) begin nerr++; $display("FAIL a_end: dones=%0d busy=%b want 1/0", done_seen - d0, bus.busy); end
    endtask

    task automatic test_back_to_back();
        int n, d0, f, dc1;
        d0 = done_seen;
        offer(3'd1, 5'b10000, 1'b0);
        wait_key(1'b1, 100, n);
        repeat (3) step();
        offer(3'd1, 5'b10000, 1'b0);
        nchk++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_held: got %b want 0", bus.in_ready); end
        wait_key(1'b0, 100, n);
        f = fall_cyc;
        nchk++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_ready_low: got %b want 0", bus.in_ready); end
        wait_key(1'b1, 100, n);
        nchk++; if (rise_cyc - f != 60) begin nerr++; $display("FAIL b2b_gap: got %0d want 60", rise_cyc - f); end
        nchk++; if (bus.done !== 1'b1 || bus.in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_pop: done=%b ready=%b want 1/1", bus.done, bus.in_ready); end
        dc1 = done_cyc;
        wait_key(1'b0, 100, n);
        nchk++; if (n != 60) begin nerr++; $display("FAIL b2b_mark2: got %0d want 60", n); end
        wait_done(100, n);
        nchk++; if (done_cyc - dc1 != 120) begin nerr++; $display("FAIL b2b_done_spacing: got %0d want 120", done_cyc - dc1); end
        step();
        nchk++; if (done_seen - d0 != 2 || bus.busy !== 1'b0) begin nerr++; $display("FAIL b2b_end: dones=%0d busy=%b want 2/0", done_seen - d0, bus.busy); end
    endtask

    task automatic test_space();
        int n, d0, r0;
        offer(3'd1, 5'b00000, 1'b0);
        wait_key(1'b1, 100, n);
        offer(3'd0, 5'b11111, 1'b1);
        wait_key(1'b0, 100, n);
        r0 = rise_cnt;
        d0 = done_seen;
        wait_done(100, n);
        nchk++; if (n != 60) begin nerr++; $display("FAIL sp_cgap: got %0d want 60", n); end
        step();
        wait_done(150, n);
        nchk++; if (n != 79) begin nerr++; $display("FAIL sp_wgap: got %0d want 79", n); end
        nchk++; if (rise_cnt != r0 || bus.key !== 1'b0) begin nerr++; $display("FAIL sp_key_low: rises=%0d want 0", rise_cnt - r0); end
        step();
        nchk++; if (done_seen - d0 != 2 || bus.busy !== 1'b0) begin nerr++; $display("FAIL sp_end: dones=%0d busy=%b want 2/0", done_seen - d0, bus.busy); end
    endtask

    task automatic test_empty();
        int n, d0, r0;
        d0 = done_seen;
        r0 = rise_cnt;
        offer(3'd0, 5'b10101, 1'b0);
        wait_done(60, n);
        nchk++; if (bus.done !== 1'b1 || uc_ph != 0) begin nerr++; $display("FAIL empty_done: done=%b phase=%0d want 1/0", bus.done, uc_ph); end
        step();
        nchk++; if (rise_cnt != r0 || done_seen - d0 != 1 || bus.busy !== 1'b0) begin nerr++; $display("FAIL empty_end: rises=%0d dones=%0d busy=%b want 0/1/0", rise_cnt - r0, done_seen - d0, bus.busy); end
    endtask

    task automatic test_len_clamp();
        int n, r0;
        r0 = rise_cnt;
        offer(3'd7, 5'b00000, 1'b0);
        wait_done(600, n);
        nchk++; if (bus.done !== 1'b1 || rise_cnt - r0 != 5) begin nerr++; $display("FAIL clamp: done=%b marks=%0d want 1/5", bus.done, rise_cnt - r0); end
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        offer(3'd1, 5'b10000, 1'b0);
        wait_key(1'b1, 100, n);
        repeat (2) step();
        offer(3'd1, 5'b00000, 1'b0);
        nchk++; if (bus.in_ready !== 1'b0 || bus.key !== 1'b1) begin nerr++; $display("FAIL rm_pre: ready=%b key=%b want 0/1", bus.in_ready, bus.key); end
        rst = 1'b0;
        #1;
        nchk++; if (bus.key !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin nerr++; $display("FAIL rm_async: key=%b ready=%b busy=%b want 0/1/0", bus.key, bus.in_ready, bus.busy); end
        n = 0;
        while (uc_ph != 2 && n < 40) begin
            step();
            n++;
        end
        rst = 1'b1;
        offer(3'd1, 5'b00000, 1'b0);
        wait_key(1'b1, 100, n);
        nchk++; if (bus.key !== 1'b1 || rise_ph != 0) begin nerr++; $display("FAIL rm_release_tick: key=%b phase=%0d want 1/0", bus.key, rise_ph); end
        wait_done(200, n);
        step();
    endtask

`ifdef MORSE_ABORT_EN
    task automatic test_abort();
        int n, d0, r0;
        offer(3'd2, 5'b01000, 1'b0);
        wait_key(1'b1, 100, n);
        offer(3'd1, 5'b00000, 1'b0);
        wait_key(1'b0, 100, n);
        repeat (5) step();
        d0 = done_seen;
        r0 = rise_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        nchk++; if (bus.key !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin nerr++; $display("FAIL abort_now: key=%b busy=%b ready=%b want 0/0/1", bus.key, bus.busy, bus.in_ready); end
        repeat (100) step();
        nchk++; if (done_seen != d0 || rise_cnt != r0) begin nerr++; $display("FAIL abort_quiet: dones=%0d rises=%0d want 0/0", done_seen - d0, rise_cnt - r0); end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_len   = 3'd0;
        bus.in_pat   = 5'd0;
        bus.in_space = 1'b0;
        test_reset();
        test_e();
        test_a();
        test_back_to_back();
        test_space();
        test_empty();
        test_len_clamp();
        test_reset_mid();
`ifdef MORSE_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
